// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that drains into a UART serializer through a one-cycle load strobe.
// Define UART_TXFIFO_IRQ_EN to build the armed low-watermark irq; otherwise irq is tied low.
//   state     | meaning
//   IDLE      | waiting for data and an idle serializer
//   LOAD      | pop one byte into tx_data and pulse tx_en
//   WAIT_BUSY | waiting for the serializer to raise busy, bounded by BUSY_TMO
//   WAIT_DONE | frame in flight, waiting for busy to fall
module uart_tx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int LOW_WM   = 4,
  parameter int BUSY_TMO = 15
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          irq
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [3:0]  TMO_LAST = 4'(BUSY_TMO - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [3:0]    tmo_cnt;
  state_t        state;
  logic          push, pop;
  logic [AW:0]   level_nxt;

  // full is the registered flag, so a pop on the same edge never frees room for a push
  assign push = wr_en && !full && !clr;
  assign pop  = (state == LOAD) && !clr;

  always_comb begin
    level_nxt = level;
    if (clr)
      level_nxt = '0;
    else if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      level <= level_nxt;
      full  <= (level_nxt == DEPTH_L);
      empty <= (level_nxt == '0);
      if (clr) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (wr_en && full)
          overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        IDLE:
          if (!clr && !empty && !tx_busy)
            state <= LOAD;
        LOAD:
          if (clr) begin
            state <= IDLE;
          end else begin
            tx_data <= mem[rd_ptr];
            tx_en   <= 1'b1;
            tmo_cnt <= '0;
            state   <= WAIT_BUSY;
          end
        WAIT_BUSY:
          if (clr)
            state <= IDLE;
          else if (tx_busy)
            state <= WAIT_DONE;
          else if (tmo_cnt == TMO_LAST)
            state <= IDLE;
          else
            tmo_cnt <= tmo_cnt + 1'b1;
        // clr does not abort a frame already shifting
        WAIT_DONE:
          if (!tx_busy)
            state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

`ifdef UART_TXFIFO_IRQ_EN
  localparam logic [AW:0] LOW_WM_L = (AW+1)'(LOW_WM);

  logic arm, arm_nxt;

  // arm keeps a never-written FIFO quiet; it drops once everything has drained
  always_comb begin
    arm_nxt = arm;
    if (push)
      arm_nxt = 1'b1;
    else if (level == '0 && state == IDLE)
      arm_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arm <= 1'b0;
      irq <= 1'b0;
    end else begin
      arm <= arm_nxt;
      irq <= arm_nxt && (level_nxt <= LOW_WM_L);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, ordering, overflow, timeout, flush, irq, async reset.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_en, full, empty, overflow, irq;
  logic [4:0] level;

  int total = 0;
  int bad = 0;
  bit found;
  int n;

`ifdef UART_TXFIFO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  uart_tx_fifo dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr      (clr),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_txen(input int max, output bit fnd, output int cnt);
    fnd = 1'b0;
    cnt = 0;
    while (!fnd && cnt < max) begin
      step();
      cnt++;
      if (tx_en === 1'b1) fnd = 1'b1;
    end
  endtask

  // serializer model: raise busy after a load, hold it, then release
  task automatic serve();
    tx_busy = 1'b1;
    step();
    step();
    tx_busy = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_level", level, 5'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_irq", irq, 1'b0);
    rstn = 1'b1;
    step();

    // single byte latency
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    chk("t1_level_e0", level, 5'd1);
    chk("t1_empty_e0", empty, 1'b0);
    chk("t1_txen_e0", tx_en, 1'b0);
    step();
    chk("t1_txen_e1", tx_en, 1'b0);
    step();
    chk("t1_txen_e2", tx_en, 1'b1);
    chk("t1_data_e2", tx_data, 8'h55);
    chk("t1_level_e2", level, 5'd0);
    chk("t1_empty_e2", empty, 1'b1);
    step();
    chk("t1_txen_e3", tx_en, 1'b0);
    chk("t1_data_hold", tx_data, 8'h55);
    repeat (20) step();

    // busy never rises: each load times out
    wr_en = 1'b1; wr_data = 8'hA1;
    step();
    wr_data = 8'hA2;
    step();
    wr_data = 8'hA3;
    step();
    wr_en = 1'b0;
    chk("t3_txen0", tx_en, 1'b1);
    chk("t3_data0", tx_data, 8'hA1);
    for (int k = 0; k < 2; k++) begin
      wait_txen(30, found, n);
      chk("t3_found", found, 1'b1);
      chk("t3_gap", n, 17);
      chk("t3_data", tx_data, 8'hA2 + 8'(k));
    end
    repeat (20) step();

    // fill to full while busy, overflow, then drain in order
    tx_busy = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    chk("t2_full16", full, 1'b1);
    chk("t2_ovf_before", overflow, 1'b0);
    wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    chk("t2_full", full, 1'b1);
    chk("t2_level", level, 5'd16);
    chk("t2_overflow", overflow, 1'b1);
    tx_busy = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'hBB;
    step();
    wr_en = 1'b0;
    chk("t6_full_txen", tx_en, 1'b1);
    chk("t6_full_data", tx_data, 8'h00);
    chk("t6_full_level", level, 5'd15);
    chk("t6_full_flag", full, 1'b0);
    for (int i = 1; i < 16; i++) begin
      serve();
      wait_txen(10, found, n);
      chk("t2_found", found, 1'b1);
      chk("t2_data", tx_data, 8'(i));
      if (i == 1) chk("t2_b2b_lat", n, 3);
    end
    chk("t2_level_end", level, 5'd0);
    chk("t2_empty_end", empty, 1'b1);
    serve();
    wait_txen(25, found, n);
    chk("t2_no_extra", found, 1'b0);

    // flush during an in-flight frame
    tx_busy = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    tx_busy = 1'b0;
    wait_txen(10, found, n);
    chk("t4_found", found, 1'b1);
    chk("t4_data", tx_data, 8'h40);
    tx_busy = 1'b1;
    step();
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    step();
    clr = 1'b0; wr_en = 1'b0;
    chk("t4_level", level, 5'd0);
    chk("t4_empty", empty, 1'b1);
    chk("t4_overflow", overflow, 1'b0);
    repeat (3) step();
    tx_busy = 1'b0;
    wait_txen(25, found, n);
    chk("t4_no_txen", found, 1'b0);
    chk("t4_level_end", level, 5'd0);

    // simultaneous push and pop at level 5
    tx_busy = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("t6_level5", level, 5'd5);
    tx_busy = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'h35;
    step();
    wr_en = 1'b0;
    chk("t6_txen", tx_en, 1'b1);
    chk("t6_data0", tx_data, 8'h30);
    chk("t6_level_same", level, 5'd5);
    for (int i = 1; i < 6; i++) begin
      serve();
      wait_txen(10, found, n);
      chk("t6_found", found, 1'b1);
      chk("t6_data", tx_data, 8'h30 + 8'(i));
    end
    serve();
    repeat (5) step();
    chk("t6_level_end", level, 5'd0);
    chk("t6_overflow", overflow, 1'b0);

    // low-watermark irq
    tx_busy = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("t5_level6", level, 5'd6);
    chk("t5_irq_l6", irq, 1'b0);
    tx_busy = 1'b0;
    wait_txen(10, found, n);
    chk("t5_found5", found, 1'b1);
    chk("t5_irq_l5", irq, 1'b0);
    serve();
    wait_txen(10, found, n);
    chk("t5_level4", level, 5'd4);
    chk("t5_irq_l4", irq, IRQ_ON);
    for (int i = 2; i < 6; i++) begin
      serve();
      wait_txen(10, found, n);
      chk("t5_drain_data", tx_data, 8'h60 + 8'(i));
    end
    serve();
    repeat (4) step();
    chk("t5_level_end", level, 5'd0);
    chk("t5_irq_idle", irq, 1'b0);

    // asynchronous reset while a strobe is high
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    wait_txen(5, found, n);
    chk("t7_found", found, 1'b1);
    chk("t7_data", tx_data, 8'h77);
    #2 rstn = 1'b0;
    #1;
    chk("t7_txen_rst", tx_en, 1'b0);
    chk("t7_data_rst", tx_data, 8'h00);
    chk("t7_empty_rst", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
